// File: rtl/ex_div_seq.sv
// Radix-2 restoring divide sequencer for the RV32 EX stage (DIV/DIVU/REM/REMU).
// Optional build macro DIV_EARLY_OUT_EN: finish immediately when |dividend| < |divisor|.
module ex_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        cancel_i,
    output logic        stall_o,
    output logic        ready_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [4:0]  cnt_r, cnt_s;
    logic [31:0] rem_r, rem_s;
    logic [31:0] quo_r, quo_s;
    logic [31:0] dvsr_r, dvsr_s;
    logic        is_rem_r, is_rem_s;
    logic        neg_q_r, neg_q_s;
    logic        neg_r_r, neg_r_s;
    logic        ready_r, ready_s;
    logic [31:0] result_r, result_s;

    logic        signed_op_s;
    logic        dvnd_neg_s;
    logic        dvsr_neg_s;
    logic [31:0] abs_dvnd_s;
    logic [31:0] abs_dvsr_s;
    logic        ovf_s;
    logic        early_s;
    logic [32:0] rem_sh_s;
    logic [32:0] trial_s;
    logic [31:0] rem_it_s;
    logic [31:0] quo_it_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Operand decode, one restoring iteration, and next-state / output selection.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        rem_s    = rem_r;
        quo_s    = quo_r;
        dvsr_s   = dvsr_r;
        is_rem_s = is_rem_r;
        neg_q_s  = neg_q_r;
        neg_r_s  = neg_r_r;
        ready_s  = ready_r;
        result_s = result_r;

        signed_op_s = ~op_i[0];
        dvnd_neg_s  = signed_op_s & dividend_i[31];
        dvsr_neg_s  = signed_op_s & divisor_i[31];
        abs_dvnd_s  = dvnd_neg_s ? neg32(dividend_i) : dividend_i;
        abs_dvsr_s  = dvsr_neg_s ? neg32(divisor_i) : divisor_i;
        ovf_s       = signed_op_s & (dividend_i == 32'h8000_0000) & (divisor_i == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
        early_s     = (abs_dvnd_s < abs_dvsr_s);
`else
        early_s     = 1'b0;
`endif

        // Partial remainder never exceeds the divisor, so 33 bits hold the shifted value.
        rem_sh_s = {rem_r, quo_r[31]};
        trial_s  = rem_sh_s - {1'b0, dvsr_r};
        if (!trial_s[32]) begin
            rem_it_s = trial_s[31:0];
            quo_it_s = {quo_r[30:0], 1'b1};
        end else begin
            rem_it_s = rem_sh_s[31:0];
            quo_it_s = {quo_r[30:0], 1'b0};
        end
        quo_fix_s = neg_q_r ? neg32(quo_it_s) : quo_it_s;
        rem_fix_s = neg_r_r ? neg32(rem_it_s) : rem_it_s;

        case (state_r)
            IDLE: begin
                if (start_i && !cancel_i) begin
                    is_rem_s = op_i[1];
                    neg_q_s  = dvnd_neg_s ^ dvsr_neg_s;
                    neg_r_s  = dvnd_neg_s;
                    rem_s    = 32'd0;
                    quo_s    = abs_dvnd_s;
                    dvsr_s   = abs_dvsr_s;
                    cnt_s    = 5'd0;
                    if (divisor_i == 32'd0) begin
                        state_s  = DONE;
                        ready_s  = 1'b1;
                        result_s = op_i[1] ? dividend_i : 32'hFFFF_FFFF;
                    end else if (ovf_s) begin
                        state_s  = DONE;
                        ready_s  = 1'b1;
                        result_s = op_i[1] ? 32'd0 : 32'h8000_0000;
                    end else if (early_s) begin
                        state_s  = DONE;
                        ready_s  = 1'b1;
                        result_s = op_i[1] ? dividend_i : 32'd0;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cancel_i) begin
                    state_s = IDLE;
                    ready_s = 1'b0;
                end else begin
                    rem_s = rem_it_s;
                    quo_s = quo_it_s;
                    cnt_s = cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        state_s  = DONE;
                        ready_s  = 1'b1;
                        result_s = is_rem_r ? rem_fix_s : quo_fix_s;
                    end else begin
                        state_s = RUN;
                    end
                end
            end
            DONE: begin
                // Waiting for start_i to drop prevents a restart from the same request.
                if (cancel_i || !start_i) begin
                    state_s = IDLE;
                    ready_s = 1'b0;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                ready_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= IDLE;
            cnt_r    <= 5'd0;
            rem_r    <= 32'd0;
            quo_r    <= 32'd0;
            dvsr_r   <= 32'd0;
            is_rem_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            ready_r  <= 1'b0;
            result_r <= 32'd0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            rem_r    <= rem_s;
            quo_r    <= quo_s;
            dvsr_r   <= dvsr_s;
            is_rem_r <= is_rem_s;
            neg_q_r  <= neg_q_s;
            neg_r_r  <= neg_r_s;
            ready_r  <= ready_s;
            result_r <= result_s;
        end
    end

    assign stall_o  = ((state_r == IDLE) & start_i & ~cancel_i) | (state_r == RUN);
    assign ready_o  = ready_r;
    assign result_o = result_r;

endmodule
